fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, 4, prefetch queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 imem_req  output  1  instruction memory read request, registered.
REQ-006 imem_addr  output  32  word-aligned read address, registered.
REQ-007 imem_ack  input  1  memory returns imem_rdata for the current request this cycle.
REQ-008 imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-009 instr_valid  output  1  queue head holds a valid instruction.
REQ-010 instr  output  32  queue head instruction word.
REQ-011 instr_pc  output  32  address of queue head instruction.
REQ-012 instr_ready  input  1  consumer (CPU decode) accepts head when instr_valid=1.
REQ-013 redirect  input  1  jump/branch/jr taken; flush and refetch.
REQ-014 redirect_pc  input  32  new fetch address; bits [1:0] forced to 0.

Function
REQ-015 States: FETCH (no request outstanding), WAIT (request outstanding), DRAIN (outstanding request whose data is discarded).
REQ-016 At most one memory request outstanding at any time.
REQ-017 FETCH: if count < DEPTH and redirect=0, next edge sets imem_req=1, imem_addr=fetch_pc, enters WAIT.
REQ-018 WAIT: imem_req and imem_addr held stable until imem_ack=1.
REQ-019 WAIT with imem_ack=1, redirect=0: push {imem_rdata, imem_addr}; fetch_pc = imem_addr+4 (32-bit wrap, 32'hFFFFFFFC -> 0).
REQ-020 Same edge: if post-edge count < DEPTH, imem_req stays 1 with imem_addr+4 and state stays WAIT (back-to-back); else imem_req=0, go FETCH.
REQ-021 Pop when instr_valid=1 and instr_ready=1; push and pop in one cycle leave count unchanged and are both honoured.
REQ-022 instr_valid = (count != 0); instr/instr_pc reflect head entry; contents undefined when instr_valid=0.
REQ-023 Fetch latency: ack in cycle N into empty queue -> instr_valid=1 in cycle N+1.
REQ-024 Redirect in FETCH: queue flushed (count=0), fetch_pc=redirect_pc&~3, imem_req=0; request issued the following cycle per REQ-017.
REQ-025 Redirect in WAIT with imem_ack=0: flush, load fetch_pc, go DRAIN; imem_req/imem_addr held until ack.
REQ-026 Redirect in WAIT with imem_ack=1 same cycle: ack data discarded, flush, load fetch_pc, imem_req=0, go FETCH.
REQ-027 DRAIN: imem_ack=1 -> data discarded, imem_req=0, go FETCH; a further redirect in DRAIN only reloads fetch_pc.
REQ-028 Redirect takes priority over a simultaneous pop; instr_valid=0 the cycle after any redirect.
REQ-029 imem_ack outside WAIT/DRAIN is ignored.

Reset
REQ-030 reset=0 immediately: state=FETCH, count=0, head/tail pointers=0, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-031 Reset mid-request abandons it; a late imem_ack after release is ignored (state FETCH).
REQ-032 First imem_req=1 at the second rising edge after reset release.

Configuration
REQ-033 Macro FETCH_STALL_COUNT_EN: when defined, adds output stall_count (32) counting cycles with instr_ready=1 and instr_valid=0, saturating at 32'hFFFFFFFF, reset to 0.
REQ-034 Without FETCH_STALL_COUNT_EN the port and counter do not exist; all other behaviour identical.

Verification
REQ-035 Reset, memory acks 1 cycle after each req, instr_ready=1 -> instr_pc sequence 0,4,8,12 with matching words, no gaps after the first.
REQ-036 instr_ready=0, DEPTH=4 -> exactly 4 requests (0..12), imem_req=0, count=4; raise instr_ready -> fetch resumes at 16.
REQ-037 Redirect to 32'h00000103 while WAIT at addr 8, ack 3 cycles later -> ack data dropped, next imem_addr=32'h00000100, first instr_pc=32'h100.
REQ-038 Redirect to 32'h40 coincident with ack at addr 20 -> word from 20 never appears; next request addr 32'h40 next cycle.
REQ-039 Redirect to 32'hFFFFFFFC -> instr_pc sequence FFFFFFFC, 00000000, 00000004.
REQ-040 reset=0 asserted while WAIT -> outputs at reset values immediately; stray ack after release ignored; FETCH_STALL_COUNT_EN build: 5 starved-ready cycles -> stall_count=5.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch queue with a single outstanding memory request; FETCH_STALL_COUNT_EN adds stall_count
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [31:0] stall_count
`endif
);
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
   localparam logic [1:0]  FETCH = 2'd0;
   localparam logic [1:0]  WAIT  = 2'd1;
   localparam logic [1:0]  DRAIN = 2'd2;

   logic [1:0]    state;
   logic          run;
   logic [31:0]   fetch_pc;
   logic [AW-1:0] head, tail;
   logic [AW:0]   count, count_nxt;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];
   logic          pop, push;
   logic [31:0]   next_addr, target;

   assign instr_valid = count != '0;
   assign instr       = q_instr[head];
   assign instr_pc    = q_pc[head];

   // queue handshakes and the address arithmetic shared by the control path
   always_comb begin
      pop       = instr_valid & instr_ready;
      push      = (state == WAIT) & imem_ack & ~redirect;
      count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
      next_addr = imem_addr + 32'd4;
      target    = redirect_pc & ~32'h3;
   end

   // request FSM, occupancy and pointers; run delays the first request by one edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         run       <= 1'b0;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         count     <= '0;
         head      <= '0;
         tail      <= '0;
      end else begin
         run <= 1'b1;
         if (redirect) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= target;
            if (state == WAIT && !imem_ack) begin
               state <= DRAIN;
            end else if (state != DRAIN || imem_ack) begin
               state    <= FETCH;
               imem_req <= 1'b0;
            end
         end else begin
            count <= count_nxt;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (state == FETCH && run && count < FULL) begin
               imem_req  <= 1'b1;
               imem_addr <= fetch_pc;
               state     <= WAIT;
            end else if (push) begin
               fetch_pc <= next_addr;
               if (count_nxt < FULL) begin
                  imem_addr <= next_addr;
               end else begin
                  imem_req <= 1'b0;
                  state    <= FETCH;
               end
            end else if (state == DRAIN && imem_ack) begin
               imem_req <= 1'b0;
               state    <= FETCH;
            end
         end
      end
   end

   // queue storage, cleared on reset so the head reads zero while empty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
      end else if (push) begin
         q_instr[tail] <= imem_rdata;
         q_pc[tail]    <= imem_addr;
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   // saturating count of cycles where decode waits on an empty queue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_count <= '0;
      else if (instr_ready && !instr_valid && stall_count != '1) stall_count <= stall_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle checks of fetch_unit plus reset and stall-count sequences
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc;
      logic        rst;
      logic        rdy;
      logic        ack;
      logic        rd;
      logic [31:0] rpc;
   } vec_t;

   vec_t tbl[$];

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_valid(instr_valid),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .redirect(redirect),
      .redirect_pc(redirect_pc)
`ifdef FETCH_STALL_COUNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // expected outputs after the edge, then inputs driven for the following cycle
   task automatic add(input int req, input int unsigned addr, input int v, input int unsigned pc,
                      input int rst, input int rdy, input int ack, input int rd, input int unsigned rpc);
      vec_t e;
      e.req = req != 0; e.addr = addr; e.v = v != 0; e.pc = pc;
      e.rst = rst != 0; e.rdy = rdy != 0; e.ack = ack != 0; e.rd = rd != 0; e.rpc = rpc;
      tbl.push_back(e);
   endtask

   initial begin
      // streaming from reset, one-cycle memory
      add(0, 'h0,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h0,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h4,  1, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h8,  1, 'h4,  0, 1, 1, 0, 'h0);
      add(1, 'hC,  1, 'h8,  0, 1, 1, 0, 'h0);
      add(1, 'h10, 1, 'hC,  1, 0, 0, 0, 'h0);
      // fill with decode stalled, then resume
      add(0, 'h0,  0, 'h0,  0, 0, 1, 0, 'h0);
      add(0, 'h0,  0, 'h0,  0, 0, 1, 0, 'h0);
      add(1, 'h0,  0, 'h0,  0, 0, 1, 0, 'h0);
      add(1, 'h4,  1, 'h0,  0, 0, 1, 0, 'h0);
      add(1, 'h8,  1, 'h0,  0, 0, 1, 0, 'h0);
      add(1, 'hC,  1, 'h0,  0, 0, 1, 0, 'h0);
      add(0, 'hC,  1, 'h0,  0, 0, 1, 0, 'h0);
      add(0, 'hC,  1, 'h0,  0, 1, 1, 0, 'h0);
      add(0, 'hC,  1, 'h4,  0, 1, 1, 0, 'h0);
      add(1, 'h10, 1, 'h8,  0, 1, 1, 0, 'h0);
      add(1, 'h14, 1, 'hC,  0, 1, 1, 0, 'h0);
      add(1, 'h18, 1, 'h10, 1, 1, 1, 0, 'h0);
      // redirect while waiting, late ack drained
      add(0, 'h0,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(0, 'h0,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h0,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h4,  1, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h8,  1, 'h4,  0, 1, 0, 1, 'h103);
      add(1, 'h8,  0, 'h0,  0, 1, 0, 0, 'h0);
      add(1, 'h8,  0, 'h0,  0, 1, 0, 0, 'h0);
      add(1, 'h8,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(0, 'h8,  0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h100, 0, 'h0, 0, 1, 1, 0, 'h0);
      add(1, 'h104, 1, 'h100, 0, 1, 1, 0, 'h0);
      // redirects coincident with acks
      add(1, 'h108, 1, 'h104, 0, 1, 1, 1, 'h14);
      add(0, 'h108, 0, 'h0, 0, 1, 1, 0, 'h0);
      add(1, 'h14, 0, 'h0,  0, 1, 1, 1, 'h40);
      add(0, 'h14, 0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h40, 0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h44, 1, 'h40, 0, 1, 1, 0, 'h0);
      add(1, 'h48, 1, 'h44, 0, 1, 1, 1, 32'hFFFF_FFFC);
      // address wrap
      add(0, 'h48, 0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 32'hFFFF_FFFC, 0, 'h0, 0, 1, 1, 0, 'h0);
      add(1, 'h0,  1, 32'hFFFF_FFFC, 0, 1, 1, 0, 'h0);
      add(1, 'h4,  1, 'h0,  0, 1, 1, 0, 'h0);
      // fill, then redirect from FETCH with a pop pending
      add(1, 'h8,  1, 'h4,  0, 0, 1, 0, 'h0);
      add(1, 'hC,  1, 'h4,  0, 0, 1, 0, 'h0);
      add(1, 'h10, 1, 'h4,  0, 0, 1, 0, 'h0);
      add(0, 'h10, 1, 'h4,  0, 1, 0, 1, 'h200);
      add(0, 'h10, 0, 'h0,  0, 1, 1, 0, 'h0);
      add(1, 'h200, 0, 'h0, 0, 1, 1, 0, 'h0);
      add(1, 'h204, 1, 'h200, 0, 1, 1, 0, 'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
         chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("row%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].v});
         if (tbl[i].v) begin
            chk($sformatf("row%0d_pc", i), instr_pc, tbl[i].pc);
            chk($sformatf("row%0d_instr", i), instr, ~tbl[i].pc);
         end
         reset       = ~tbl[i].rst;
         instr_ready = tbl[i].rdy;
         redirect    = tbl[i].rd;
         redirect_pc = tbl[i].rpc;
         imem_ack    = tbl[i].ack & imem_req;
         imem_rdata  = ~imem_addr;
      end

      // reset asserted mid-request takes effect without a clock edge
      @(posedge clk);
      #1;
      chk("wait_req_before_rst", {31'b0, imem_req}, 32'h1);
      reset = 1'b0;
      #1;
      chk("async_req", {31'b0, imem_req}, 32'h0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_valid", {31'b0, instr_valid}, 32'h0);
      chk("async_instr", instr, 32'h0);
      chk("async_pc", instr_pc, 32'h0);
      // stray ack after release is ignored
      redirect = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("stray_req", {31'b0, imem_req}, 32'h0);
      chk("stray_valid", {31'b0, instr_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("resume_req", {31'b0, imem_req}, 32'h1);
      chk("resume_addr", imem_addr, 32'h0);
      chk("resume_valid", {31'b0, instr_valid}, 32'h0);

`ifdef FETCH_STALL_COUNT_EN
      reset = 1'b0;
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("stall_rst", stall_count, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_5", stall_count, 32'd5);
      instr_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_hold", stall_count, 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
